// File: rtl/e_mdu_pkg.sv
// rtl/e_mdu_pkg.sv - MDU operation codes and op-class helpers shared by the E-stage MDU
package e_mdu_pkg;

  localparam int MDU_OP_LEN = 4;

  typedef enum logic [MDU_OP_LEN-1:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  function automatic logic is_md_op(input logic [MDU_OP_LEN-1:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_mul_op(input logic [MDU_OP_LEN-1:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  // Decode stalls any MDU-touching instruction while an operation is starting or in flight.
  function automatic logic mdu_stall(input logic start, input logic busy, input logic d_md_op);
    return (start | busy) & d_md_op;
  endfunction

endpackage

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - execute-stage multiply/divide unit owning HI/LO with a fixed busy window
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [MDU_OP_LEN-1:0] MDUOp,
  input  logic [31:0]           A,
  input  logic [31:0]           B,
  output logic                  Busy,
  output logic [31:0]           HiloOut,
  output logic [31:0]           Hi,
  output logic [31:0]           Lo
);

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] phi_q, phi_d, plo_q, plo_d;
  logic        pwr_q, pwr_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [63:0] mul_s, mul_u;
  logic [31:0] dv, q_s, r_s, q_u, r_u;
  logic        accept, div_ovf;

  always_comb begin
    // Divisor forced non-zero so the operators never see /0; that result is discarded anyway.
    dv      = (B == 32'd0) ? 32'd1 : B;
    mul_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    mul_u   = {32'd0, A} * {32'd0, B};
    q_s     = $signed(A) / $signed(dv);
    r_s     = $signed(A) % $signed(dv);
    q_u     = A / dv;
    r_u     = A % dv;
    div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    accept  = Start && (cnt_q == 4'd0) && is_md_op(MDUOp);

    hi_d  = hi_q;
    lo_d  = lo_q;
    phi_d = phi_q;
    plo_d = plo_q;
    pwr_d = pwr_q;
    cnt_d = cnt_q;

    if (accept) begin
      cnt_d = is_mul_op(MDUOp) ? 4'(MUL_CYCLES) : 4'(DIV_CYCLES);
      pwr_d = is_mul_op(MDUOp) || (B != 32'd0);
      case (MDUOp)
        MDU_MULT:  {phi_d, plo_d} = mul_s;
        MDU_MULTU: {phi_d, plo_d} = mul_u;
        MDU_DIV: begin
          phi_d = div_ovf ? 32'd0 : r_s;
          plo_d = div_ovf ? 32'h8000_0000 : q_s;
        end
        default: begin
          phi_d = r_u;
          plo_d = q_u;
        end
      endcase
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1 && pwr_q) begin
        hi_d  = phi_q;
        lo_d  = plo_q;
        pwr_d = 1'b0;
      end
    end else if (!Start) begin
      if (MDUOp == MDU_MTHI) hi_d = A;
      if (MDUOp == MDU_MTLO) lo_d = A;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
      phi_q <= 32'd0;
      plo_q <= 32'd0;
      pwr_q <= 1'b0;
      cnt_q <= 4'd0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      phi_q <= phi_d;
      plo_q <= plo_d;
      pwr_q <= pwr_d;
      cnt_q <= cnt_d;
    end
  end

  assign Busy    = (cnt_q != 4'd0);
  assign Hi      = hi_q;
  assign Lo      = lo_q;
  assign HiloOut = (MDUOp == MDU_MFHI) ? hi_q :
                   (MDUOp == MDU_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - directed self-checking bench for e_mdu
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HiloOut;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int total = 0;
  int bad   = 0;

  e_mdu #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .MDUOp(MDUOp), .A(A), .B(B),
    .Busy(Busy), .HiloOut(HiloOut), .Hi(Hi), .Lo(Lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; MDUOp = op; A = a; B = b;
    step();
    Start = 1'b0; MDUOp = MDU_NONE; A = 32'd0; B = 32'd0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (Busy && n < 40) begin
      n++;
      step();
    end
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] a);
    Start = 1'b0; MDUOp = op; A = a;
    step();
    MDUOp = MDU_NONE; A = 32'd0;
  endtask

  int n;

  initial begin
    Reset = 1'b0; Start = 1'b0; MDUOp = MDU_NONE; A = 32'd0; B = 32'd0;
    step(); step();
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_hi", Hi, 32'd0);
    chk("rst_lo", Lo, 32'd0);
    Reset = 1'b1;
    step();

    issue(MDU_MULT, 32'hFFFF_FFFD, 32'd5);
    count_busy(n);
    chk("mult_busy", n, 32'd5);
    chk("mult_hi", Hi, 32'hFFFF_FFFF);
    chk("mult_lo", Lo, 32'hFFFF_FFF1);

    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
    count_busy(n);
    chk("multu_busy", n, 32'd5);
    chk("multu_hi", Hi, 32'h0000_0001);
    chk("multu_lo", Lo, 32'hFFFF_FFFE);
    MDUOp = MDU_MFHI; #1;
    chk("mfhi_out", HiloOut, 32'h0000_0001);
    MDUOp = MDU_MFLO; #1;
    chk("mflo_out", HiloOut, 32'hFFFF_FFFE);
    MDUOp = MDU_NONE; #1;
    chk("none_out", HiloOut, 32'd0);

    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    chk("div_busy", n, 32'd10);
    chk("div_lo", Lo, 32'hFFFF_FFFD);
    chk("div_hi", Hi, 32'hFFFF_FFFF);

    issue(MDU_DIVU, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    chk("divu_busy", n, 32'd10);
    chk("divu_lo", Lo, 32'h7FFF_FFFC);
    chk("divu_hi", Hi, 32'h0000_0001);

    move_to(MDU_MTHI, 32'h11);
    move_to(MDU_MTLO, 32'h22);
    chk("mthi", Hi, 32'h11);
    chk("mtlo", Lo, 32'h22);
    issue(MDU_DIV, 32'd1234, 32'd0);
    count_busy(n);
    chk("div0_busy", n, 32'd10);
    chk("div0_hi", Hi, 32'h11);
    chk("div0_lo", Lo, 32'h22);

    issue(MDU_MULT, 32'd2, 32'd3);
    chk("mul23_busy", {31'd0, Busy}, 32'd1);
    MDUOp = MDU_MFHI; #1;
    chk("mfhi_during_busy", HiloOut, 32'h11);
    move_to(MDU_MTHI, 32'hABCD);
    chk("mthi_ignored", Hi, 32'h11);
    issue(MDU_DIV, 32'd100, 32'd7);
    count_busy(n);
    chk("mul23_rest_busy", n, 32'd3);
    chk("mul23_hi", Hi, 32'd0);
    chk("mul23_lo", Lo, 32'd6);
    step(); step();
    chk("second_start_ignored", {31'd0, Busy}, 32'd0);

    issue(MDU_NONE, 32'h7, 32'h7);
    chk("start_none_busy", {31'd0, Busy}, 32'd0);
    issue(4'hF, 32'h7, 32'h7);
    chk("undef_busy", {31'd0, Busy}, 32'd0);
    chk("undef_lo", Lo, 32'd6);
    MDUOp = 4'hF; #1;
    chk("undef_out", HiloOut, 32'd0);
    MDUOp = MDU_NONE;

    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    chk("ovf_lo", Lo, 32'h8000_0000);
    chk("ovf_hi", Hi, 32'd0);

    issue(MDU_DIV, 32'd100, 32'd7);
    step(); step(); step();
    chk("pre_rst_busy", {31'd0, Busy}, 32'd1);
    Reset = 1'b0; #1;
    chk("midrst_busy", {31'd0, Busy}, 32'd0);
    chk("midrst_hi", Hi, 32'd0);
    chk("midrst_lo", Lo, 32'd0);
    step();
    Reset = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("no_commit_hi", Hi, 32'd0);
    chk("no_commit_lo", Lo, 32'd0);
    chk("no_commit_busy", {31'd0, Busy}, 32'd0);
    move_to(MDU_MTLO, 32'h55);
    chk("mtlo_after_rst", Lo, 32'h55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
